mem_port_arbiter: RTL

- Shares one variable-latency memory port between two requesters: the CPU instruction fetch and the CPU data load/store.
- Sits between the CPU core and the external memory model. It replaces the separate instruction and data buses with a single sequenced bus.
- Data accesses normally take priority. A starvation guard and a memory timeout are built in.
- Each requester receives a one-cycle response pulse carrying the read data and an error flag.

---
 rtl/mem_port_arbiter_pkg.sv | 29 ++
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter_timeout_counter.sv | 39 +++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and defaults for the memory port arbiter
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam int MAX_DATA_RUN_DEF = 4;
  localparam int TIMEOUT_DEF      = 16;
  localparam int CNT_W_DEF        = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    D_BUSY  = 2'b01,
    IF_BUSY = 2'b10,
    RESP    = 2'b11
  } arb_state_e;

  typedef enum logic {
    GNT_D  = 1'b0,
    GNT_IF = 1'b1
  } arb_gnt_e;

  // Width needed to hold a run count that saturates at max_run.
  function automatic int run_cnt_width(input int max_run);
    return (max_run < 1) ? 1 : $clog2(max_run + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - CPU fetch/data buses and the shared memory port
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [STRB_W-1:0] d_wstrb;
  logic [DATA_W-1:0] d_wdata;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;

  logic              resp_err;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [STRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              busy;

  // Arbiter view
  modport slave (
    input  if_req, if_addr, d_req, d_addr, d_wstrb, d_wdata, mem_rdata, mem_ready,
    output if_valid, if_rdata, d_valid, d_rdata, resp_err,
           mem_req, mem_addr, mem_wstrb, mem_wdata, busy
  );

  // CPU core plus memory model view
  modport master (
    output if_req, if_addr, d_req, d_addr, d_wstrb, d_wdata, mem_rdata, mem_ready,
    input  if_valid, if_rdata, d_valid, d_rdata, resp_err,
           mem_req, mem_addr, mem_wstrb, mem_wdata, busy
  );

endinterface

// File: rtl/mem_port_arbiter_timeout_counter.sv
// rtl/mem_port_arbiter_timeout_counter.sv - clearable up-counter with terminal-count flag
module arb_timeout_counter #(
  parameter int CNT_W  = 5,
  parameter int TC_VAL = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(TC_VAL);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over count; hold otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter onto one variable-latency memory port
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DATA_RUN = MAX_DATA_RUN_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  localparam int               RUN_W   = run_cnt_width(MAX_DATA_RUN);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

  arb_state_e        state_q, state_d;
  arb_gnt_e          gnt_q, gnt_d;
  logic [RUN_W-1:0]  run_q, run_d;

  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic              in_busy;
  logic              tmo_tc;
  logic              data_ok;

  assign in_busy = (state_q == D_BUSY) || (state_q == IF_BUSY);

  // The count restarts from zero on every entry into a busy state.
  arb_timeout_counter #(
    .CNT_W  (CNT_W),
    .TC_VAL (TIMEOUT - 1)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == IDLE),
    .en_i  (in_busy),
    .tc_o  (tmo_tc)
  );

  // Data wins unless fetch has been starved for MAX_DATA_RUN data grants.
  assign data_ok = bus.d_req && !(bus.if_req && (run_q == RUN_MAX));

  // Arbitration, access sequencing and response generation
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    run_d       = run_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    resp_err_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (data_ok) begin
          state_d     = D_BUSY;
          gnt_d       = GNT_D;
          run_d       = bus.if_req ? run_q + 1'b1 : '0;
          mem_req_d   = 1'b1;
          mem_addr_d  = bus.d_addr;
          mem_wstrb_d = bus.d_wstrb;
          mem_wdata_d = bus.d_wdata;
        end else if (bus.if_req) begin
          state_d     = IF_BUSY;
          gnt_d       = GNT_IF;
          run_d       = '0;
          mem_req_d   = 1'b1;
          mem_addr_d  = bus.if_addr;
          mem_wstrb_d = '0;
          mem_wdata_d = '0;
        end else begin
          mem_req_d = 1'b0;
        end
      end

      D_BUSY, IF_BUSY: begin
        // mem_ready has priority over a coincident timeout.
        if (bus.mem_ready || tmo_tc) begin
          state_d    = RESP;
          mem_req_d  = 1'b0;
          resp_err_d = !bus.mem_ready;
          if (gnt_q == GNT_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
          end else begin
            d_valid_d  = 1'b1;
            d_rdata_d  = bus.mem_ready ? bus.mem_rdata : '0;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_D;
      run_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      resp_err_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      run_q       <= run_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      resp_err_q  <= resp_err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.resp_err  = resp_err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
